// File: rtl/rgu_result_fifo_reader.sv
// Receives the RGU PUSH result stream into a circular buffer and re-presents it over valid/ready.
// Optional statistics outputs (drop counter, high-water mark) are enabled by RGU_FIFO_STATS_EN.
module rgu_result_fifo_reader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iFifoPush,
    input  logic [DATA_W-1:0] iFifoData,
    output logic              oValid,
    output logic [DATA_W-1:0] oData,
    input  logic              iReady,
    output logic [AW:0]       oCount,
    output logic              oFull,
    output logic              oOverflow,
    input  logic              iClearOvf
`ifdef RGU_FIFO_STATS_EN
    ,
    output logic [15:0]       oDropCount,
    output logic [AW:0]       oHighWater
`endif
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_inc;
    logic [AW:0]       count;
    logic [AW:0]       count_next;
    logic              pop;
    logic              push_accept;
    logic              drop;
    logic              valid_next;
    logic [DATA_W-1:0] head_next;

    assign oCount = count;

    // Full is decided from count, so a pop in the same cycle frees the slot being written.
    always_comb begin
        pop         = oValid & iReady;
        push_accept = iFifoPush & ((count != DEPTH_C) | pop);
        drop        = iFifoPush & ~push_accept;
        rd_ptr_inc  = rd_ptr + PTR_ONE;

        count_next = count;
        case ({push_accept, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // oData is a registered copy of the head; the pushed word bypasses the RAM when it becomes head.
    always_comb begin
        valid_next = oValid;
        head_next  = oData;
        if (pop) begin
            if (count == CNT_ONE) begin
                valid_next = push_accept;
                head_next  = push_accept ? iFifoData : oData;
            end else begin
                valid_next = 1'b1;
                head_next  = mem[rd_ptr_inc];
            end
        end else if (!oValid && push_accept) begin
            valid_next = 1'b1;
            head_next  = iFifoData;
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by count, so its contents never matter.
    always_ff @(posedge iClock) begin
        if (push_accept) begin
            mem[wr_ptr] <= iFifoData;
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            oValid    <= 1'b0;
            oData     <= '0;
            oFull     <= 1'b0;
            oOverflow <= 1'b0;
        end else begin
            if (push_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            count     <= count_next;
            oValid    <= valid_next;
            oData     <= head_next;
            oFull     <= (count_next == DEPTH_C);
            oOverflow <= drop | (oOverflow & ~iClearOvf);
        end
    end

`ifdef RGU_FIFO_STATS_EN
    // A drop coinciding with a clear is counted as the first drop of the new window.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            oDropCount <= '0;
            oHighWater <= '0;
        end else begin
            if (iClearOvf) begin
                oDropCount <= drop ? 16'd1 : 16'd0;
                oHighWater <= count_next;
            end else begin
                if (drop && oDropCount != 16'hFFFF) begin
                    oDropCount <= oDropCount + 16'd1;
                end
                if (count_next > oHighWater) begin
                    oHighWater <= count_next;
                end
            end
        end
    end
`endif

endmodule
